qea_host_sequencer: RTL and testbench

Synthesizable host-side sequencer for the QEA accelerator. It streams gate-context words into the context RAM, initialises the state RAM to |0…0⟩, and pulses start. It then waits for completion with a cycle counter and optional timeout, and streams the final state vector out over a valid/ready port. It sits between the system interconnect and QEA, generalising the load/start/poll/readout sequence to any PE count, qubit count and instruction count.

---
 rtl/qea_host_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_qea_host_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/qea_host_sequencer.sv
// Host-side run sequencer for QEA: loads gate context, initialises the state
// RAM to |0...0>, starts the core, waits for completion and streams the state out.
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int CYCLE_CNT_WIDTH         = 32,
    parameter int RD_LATENCY              = 2,
    parameter logic [STATE_DATA_WIDTH-1:0] INIT_AMP = 64'h40000000_00000000
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_go,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH:0]     i_ins_num,
    input  logic [CYCLE_CNT_WIDTH-1:0]           i_timeout,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic                                 o_state_ena,
    output logic                                 o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    output logic                                 o_start,
    input  logic                                 i_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_rd_last,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_timeout_err,
    output logic                                 o_cfg_err,
    output logic [CYCLE_CNT_WIDTH-1:0]           o_cycles
);

    localparam int SW       = PE_NUM * STATE_DATA_WIDTH;
    localparam int MAX_QBIT = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
    localparam int LAT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [SW-1:0] INIT_WORD = SW'(INIT_AMP) << (SW - STATE_DATA_WIDTH);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_CTX, S_LOAD_STATE, S_START, S_WAIT,
        S_RD_REQ, S_RD_WAIT, S_RD_OUT, S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [GATE_CONTEXT_ADDR_WIDTH:0]   ins_reg, ins_next;
    logic [GATE_CONTEXT_ADDR_WIDTH:0]   loaded_reg, loaded_next;
    logic [CYCLE_CNT_WIDTH-1:0]         timeout_reg, timeout_next;
    logic [STATE_ADDR_WIDTH-1:0]        word_last_reg, word_last_next;
    logic [STATE_ADDR_WIDTH-1:0]        idx_reg, idx_next;
    logic [LAT_W-1:0]                   lat_reg, lat_next;
    logic                               first_wait_reg, first_wait_next;

    logic                               ctx_ready_reg, ctx_ready_next;
    logic                               ctx_we_reg, ctx_we_next;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ctx_addr_reg, ctx_addr_next;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0] ctx_data_reg, ctx_data_next;
    logic                               state_ena_reg, state_ena_next;
    logic                               state_wea_reg, state_wea_next;
    logic [STATE_ADDR_WIDTH-1:0]        state_addra_reg, state_addra_next;
    logic [SW-1:0]                      state_dina_reg, state_dina_next;
    logic                               start_reg, start_next;
    logic                               rd_valid_reg, rd_valid_next;
    logic [SW-1:0]                      rd_data_reg, rd_data_next;
    logic                               rd_last_reg, rd_last_next;
    logic                               busy_reg, busy_next;
    logic                               done_reg, done_next;
    logic                               timeout_err_reg, timeout_err_next;
    logic                               cfg_err_reg, cfg_err_next;
    logic [CYCLE_CNT_WIDTH-1:0]         cycles_reg, cycles_next;

    logic [MAX_QBIT_WIDTH-1:0]          addr_bits;
    logic [STATE_ADDR_WIDTH:0]          word_cnt;
    logic                               cfg_bad;
    logic [CYCLE_CNT_WIDTH-1:0]         cycles_inc;
    logic                               ram_wr, ram_rd;
    logic [STATE_ADDR_WIDTH-1:0]        ram_idx;

    // Word count is 2^max(qbit-PE_NUM_WIDTH, 0); only meaningful when the config is legal.
    assign addr_bits  = (i_qbit_num > MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
                      ? i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH) : '0;
    assign word_cnt   = (STATE_ADDR_WIDTH+1)'(1) << addr_bits;
    assign cfg_bad    = (i_qbit_num > MAX_QBIT_WIDTH'(MAX_QBIT));
    assign cycles_inc = (cycles_reg == '1) ? cycles_reg : cycles_reg + 1'b1;

    always_comb begin
        state_next       = state_reg;
        ins_next         = ins_reg;
        loaded_next      = loaded_reg;
        timeout_next     = timeout_reg;
        word_last_next   = word_last_reg;
        idx_next         = idx_reg;
        lat_next         = lat_reg;
        first_wait_next  = 1'b0;
        ctx_ready_next   = 1'b0;
        ctx_we_next      = 1'b0;
        ctx_addr_next    = ctx_addr_reg;
        ctx_data_next    = ctx_data_reg;
        state_ena_next   = 1'b0;
        state_wea_next   = 1'b0;
        state_addra_next = state_addra_reg;
        state_dina_next  = state_dina_reg;
        start_next       = 1'b0;
        rd_valid_next    = 1'b0;
        rd_data_next     = rd_data_reg;
        rd_last_next     = rd_last_reg;
        done_next        = 1'b0;
        timeout_err_next = timeout_err_reg;
        cfg_err_next     = cfg_err_reg;
        cycles_next      = cycles_reg;
        ram_wr           = 1'b0;
        ram_rd           = 1'b0;
        ram_idx          = idx_reg;

        case (state_reg)
            S_IDLE: begin
                if (i_go) begin
                    ins_next         = i_ins_num;
                    timeout_next     = i_timeout;
                    word_last_next   = STATE_ADDR_WIDTH'(word_cnt - 1'b1);
                    loaded_next      = '0;
                    idx_next         = '0;
                    timeout_err_next = 1'b0;
                    cfg_err_next     = 1'b0;
                    if (cfg_bad) begin
                        cfg_err_next = 1'b1;
                        done_next    = 1'b1;
                        state_next   = S_DONE;
                    end else if (i_ins_num != '0) begin
                        ctx_ready_next = 1'b1;
                        state_next     = S_LOAD_CTX;
                    end else begin
                        ram_wr     = 1'b1;
                        ram_idx    = '0;
                        state_next = S_LOAD_STATE;
                    end
                end
            end
            S_LOAD_CTX: begin
                ctx_ready_next = 1'b1;
                if (i_ctx_valid && ctx_ready_reg) begin
                    ctx_we_next   = 1'b1;
                    ctx_addr_next = loaded_reg[GATE_CONTEXT_ADDR_WIDTH-1:0];
                    ctx_data_next = i_ctx_data;
                    loaded_next   = loaded_reg + 1'b1;
                    // Last beat: first state-init write goes out alongside it.
                    if (loaded_reg + 1'b1 == ins_reg) begin
                        ctx_ready_next = 1'b0;
                        ram_wr         = 1'b1;
                        ram_idx        = '0;
                        state_next     = S_LOAD_STATE;
                    end
                end
            end
            S_LOAD_STATE: begin
                if (idx_reg == word_last_reg) begin
                    start_next  = 1'b1;
                    cycles_next = '0;
                    state_next  = S_START;
                end else begin
                    idx_next = idx_reg + 1'b1;
                    ram_wr   = 1'b1;
                    ram_idx  = idx_reg + 1'b1;
                end
            end
            S_START: begin
                first_wait_next = 1'b1;
                cycles_next     = cycles_inc;
                state_next      = S_WAIT;
            end
            S_WAIT: begin
                // Complete may still be high from the previous run on the first cycle.
                if (i_complete && !first_wait_reg) begin
                    idx_next   = '0;
                    ram_rd     = 1'b1;
                    ram_idx    = '0;
                    state_next = S_RD_REQ;
                end else if (timeout_reg != '0 && cycles_reg == timeout_reg) begin
                    timeout_err_next = 1'b1;
                    done_next        = 1'b1;
                    state_next       = S_DONE;
                end else begin
                    cycles_next = cycles_inc;
                end
            end
            S_RD_REQ: begin
                lat_next   = '0;
                state_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_reg == LAT_W'(RD_LATENCY - 1)) begin
                    rd_valid_next = 1'b1;
                    rd_data_next  = i_state_dout;
                    rd_last_next  = (idx_reg == word_last_reg);
                    state_next    = S_RD_OUT;
                end else begin
                    lat_next = lat_reg + 1'b1;
                end
            end
            S_RD_OUT: begin
                if (i_rd_ready) begin
                    if (idx_reg == word_last_reg) begin
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        ram_rd     = 1'b1;
                        ram_idx    = idx_reg + 1'b1;
                        state_next = S_RD_REQ;
                    end
                end else begin
                    rd_valid_next = 1'b1;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        if (ram_wr || ram_rd) begin
            state_ena_next   = 1'b1;
            state_wea_next   = ram_wr;
            state_addra_next = ram_idx;
        end
        if (ram_wr) begin
            state_dina_next = (ram_idx == '0) ? INIT_WORD : '0;
        end
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            ins_reg         <= '0;
            loaded_reg      <= '0;
            timeout_reg     <= '0;
            word_last_reg   <= '0;
            idx_reg         <= '0;
            lat_reg         <= '0;
            first_wait_reg  <= 1'b0;
            ctx_ready_reg   <= 1'b0;
            ctx_we_reg      <= 1'b0;
            ctx_addr_reg    <= '0;
            ctx_data_reg    <= '0;
            state_ena_reg   <= 1'b0;
            state_wea_reg   <= 1'b0;
            state_addra_reg <= '0;
            state_dina_reg  <= '0;
            start_reg       <= 1'b0;
            rd_valid_reg    <= 1'b0;
            rd_data_reg     <= '0;
            rd_last_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            cfg_err_reg     <= 1'b0;
            cycles_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            ins_reg         <= ins_next;
            loaded_reg      <= loaded_next;
            timeout_reg     <= timeout_next;
            word_last_reg   <= word_last_next;
            idx_reg         <= idx_next;
            lat_reg         <= lat_next;
            first_wait_reg  <= first_wait_next;
            ctx_ready_reg   <= ctx_ready_next;
            ctx_we_reg      <= ctx_we_next;
            ctx_addr_reg    <= ctx_addr_next;
            ctx_data_reg    <= ctx_data_next;
            state_ena_reg   <= state_ena_next;
            state_wea_reg   <= state_wea_next;
            state_addra_reg <= state_addra_next;
            state_dina_reg  <= state_dina_next;
            start_reg       <= start_next;
            rd_valid_reg    <= rd_valid_next;
            rd_data_reg     <= rd_data_next;
            rd_last_reg     <= rd_last_next;
            busy_reg        <= busy_next;
            done_reg        <= done_next;
            timeout_err_reg <= timeout_err_next;
            cfg_err_reg     <= cfg_err_next;
            cycles_reg      <= cycles_next;
        end
    end

    assign o_ctx_ready   = ctx_ready_reg;
    assign o_ctx_en      = ctx_we_reg;
    assign o_ctx_wea     = ctx_we_reg;
    assign o_ctx_addr    = ctx_addr_reg;
    assign o_ctx_data    = ctx_data_reg;
    assign o_state_ena   = state_ena_reg;
    assign o_state_wea   = state_wea_reg;
    assign o_state_addra = state_addra_reg;
    assign o_state_dina  = state_dina_reg;
    assign o_start       = start_reg;
    assign o_rd_valid    = rd_valid_reg;
    assign o_rd_data     = rd_data_reg;
    assign o_rd_last     = rd_last_reg;
    assign o_busy        = busy_reg;
    assign o_done        = done_reg;
    assign o_timeout_err = timeout_err_reg;
    assign o_cfg_err     = cfg_err_reg;
    assign o_cycles      = cycles_reg;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Directed bench for qea_host_sequencer: table of whole runs plus hand-written
// reset sequences, with a behavioural QEA state RAM (2-cycle read latency).
module tb_qea_host_sequencer;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_go;
    logic [5:0]     i_qbit_num;
    logic [16:0]    i_ins_num;
    logic [31:0]    i_timeout;
    logic           i_ctx_valid;
    logic           o_ctx_ready;
    logic [63:0]    i_ctx_data;
    logic           o_ctx_en, o_ctx_wea;
    logic [15:0]    o_ctx_addr;
    logic [63:0]    o_ctx_data;
    logic           o_state_ena, o_state_wea;
    logic [15:0]    o_state_addra;
    logic [255:0]   o_state_dina;
    logic           o_start;
    logic           i_complete;
    logic [255:0]   i_state_dout;
    logic           o_rd_valid;
    logic           i_rd_ready;
    logic [255:0]   o_rd_data;
    logic           o_rd_last;
    logic           o_busy, o_done, o_timeout_err, o_cfg_err;
    logic [31:0]    o_cycles;

    qea_host_sequencer dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_qbit_num(i_qbit_num),
        .i_ins_num(i_ins_num), .i_timeout(i_timeout),
        .i_ctx_valid(i_ctx_valid), .o_ctx_ready(o_ctx_ready), .i_ctx_data(i_ctx_data),
        .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr),
        .o_ctx_data(o_ctx_data), .o_state_ena(o_state_ena), .o_state_wea(o_state_wea),
        .o_state_addra(o_state_addra), .o_state_dina(o_state_dina), .o_start(o_start),
        .i_complete(i_complete), .i_state_dout(i_state_dout), .o_rd_valid(o_rd_valid),
        .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data), .o_rd_last(o_rd_last),
        .o_busy(o_busy), .o_done(o_done), .o_timeout_err(o_timeout_err),
        .o_cfg_err(o_cfg_err), .o_cycles(o_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int qbit; int ins; int tmo; int cdelay; int stale; int gap; int stall;
        int e_ctx; int e_st; int e_start; int e_cycles; int e_rd; int e_terr; int e_cerr;
    } vec_t;

    localparam logic [255:0] INIT_WORD = {64'h40000000_00000000, 192'h0};

    int n_pass = 0;
    int n_total = 0;

    vec_t cur;
    int step_cnt, ctx_wr_cnt, st_wr_cnt, start_cnt, done_cnt, rd_cnt, sent, since, stall_cnt;
    bit started, gap_phase, prev_st_we, rd_waiting;
    logic [255:0] held_data;
    logic         held_last;

    function automatic logic [63:0] ctx_word(input int i);
        return 64'hC7C7_0000_0000_0000 + 64'(i) * 64'h10001;
    endfunction

    function automatic logic [255:0] pattern(input int k);
        return {64'h1111_0000_0000_0000 + 64'(k), 64'hDEAD_0000 + 64'(k),
                64'(k * 3 + 1), 64'hC0DE_0000_0000_0000 | 64'(k)};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Behavioural QEA state RAM; the "computation" rewrites it with a known pattern on start.
    logic [255:0] mem [256];
    logic [255:0] rd_pipe0, rd_pipe1;
    always @(posedge clk) begin
        if (o_state_ena && o_state_wea) mem[o_state_addra[7:0]] <= o_state_dina;
        if (o_start) for (int k = 0; k < 256; k++) mem[k] <= pattern(k);
        if (o_state_ena && !o_state_wea) rd_pipe0 <= mem[o_state_addra[7:0]];
        rd_pipe1 <= rd_pipe0;
    end
    assign i_state_dout = rd_pipe1;

    task automatic begin_run(input vec_t v);
        cur = v;
        step_cnt = 0; ctx_wr_cnt = 0; st_wr_cnt = 0; start_cnt = 0; done_cnt = 0;
        rd_cnt = 0; sent = 0; since = 0; stall_cnt = 0;
        started = 0; gap_phase = 0; prev_st_we = 0; rd_waiting = 0;
        @(negedge clk);
        i_qbit_num = 6'(v.qbit);
        i_ins_num  = 17'(v.ins);
        i_timeout  = 32'(v.tmo);
        i_go       = 1'b1;
    endtask

    // One cycle: observe outputs mid-cycle, then drive inputs for the next edge.
    task automatic step();
        @(negedge clk);
        step_cnt++;
        if (o_ctx_en && o_ctx_wea) begin
            check("ctx_addr", 256'(o_ctx_addr), 256'(ctx_wr_cnt));
            check("ctx_data", 256'(o_ctx_data), 256'(ctx_word(ctx_wr_cnt)));
            ctx_wr_cnt++;
        end
        if (o_state_ena && o_state_wea) begin
            check("init_addr", 256'(o_state_addra), 256'(st_wr_cnt));
            check("init_data", o_state_dina, (st_wr_cnt == 0) ? INIT_WORD : 256'h0);
            st_wr_cnt++;
        end
        if (o_start) begin
            check("start_after_init", 256'(prev_st_we), 256'(1));
            start_cnt++;
            started = 1;
            since = 0;
        end else if (started) begin
            since++;
        end
        prev_st_we = o_state_ena && o_state_wea;
        if (o_done) done_cnt++;

        gap_phase   = !gap_phase;
        i_ctx_valid = (sent < cur.ins) && (cur.gap == 0 || gap_phase);
        i_ctx_data  = ctx_word(sent);
        if (i_ctx_valid && o_ctx_ready) sent++;

        i_complete = started && ((since == cur.cdelay && cur.cdelay != 0) ||
                                 (cur.stale != 0 && since == 1));

        if (o_rd_valid) begin
            if (rd_waiting) begin
                check("rd_hold_data", o_rd_data, held_data);
                check("rd_hold_last", 256'(o_rd_last), 256'(held_last));
            end
            if (stall_cnt >= cur.stall) begin
                i_rd_ready = 1'b1;
                check("rd_data", o_rd_data, pattern(rd_cnt));
                check("rd_last", 256'(o_rd_last), 256'(rd_cnt == cur.e_rd - 1));
                rd_cnt++;
                rd_waiting = 0;
                stall_cnt = 0;
            end else begin
                i_rd_ready = 1'b0;
                stall_cnt++;
                rd_waiting = 1;
                held_data = o_rd_data;
                held_last = o_rd_last;
            end
        end else begin
            i_rd_ready = (cur.stall == 0);
        end

        // A go pulse mid-run must be ignored.
        i_go = o_busy && (step_cnt == 5);
    endtask

    task automatic do_run(input vec_t v, input string tag);
        bit seen_done;
        seen_done = 0;
        begin_run(v);
        for (int c = 0; c < 3000 && !seen_done; c++) begin
            step();
            if (o_done) seen_done = 1;
        end
        check({tag, "_done_seen"}, 256'(seen_done), 256'(1));
        check({tag, "_terr"},   256'(o_timeout_err), 256'(v.e_terr));
        check({tag, "_cerr"},   256'(o_cfg_err), 256'(v.e_cerr));
        check({tag, "_cycles"}, 256'(o_cycles), 256'(v.e_cycles));
        step();
        check({tag, "_ctx_wr"},   256'(ctx_wr_cnt), 256'(v.e_ctx));
        check({tag, "_init_wr"},  256'(st_wr_cnt), 256'(v.e_st));
        check({tag, "_starts"},   256'(start_cnt), 256'(v.e_start));
        check({tag, "_rd_words"}, 256'(rd_cnt), 256'(v.e_rd));
        check({tag, "_dones"},    256'(done_cnt), 256'(1));
        check({tag, "_idle"},     256'(o_busy), 256'(0));
        $display("run %s qbit=%0d ins=%0d: ctx=%0d init=%0d rd=%0d cycles=%0d terr=%0b cerr=%0b",
                 tag, v.qbit, v.ins, ctx_wr_cnt, st_wr_cnt, rd_cnt, o_cycles, o_timeout_err, o_cfg_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 256'({o_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_state_ena,
                                   o_state_wea, o_state_addra, o_start, o_rd_valid, o_rd_last,
                                   o_busy, o_done, o_timeout_err, o_cfg_err, o_cycles}), 256'h0);
        check({tag, "_ctx_data"}, 256'(o_ctx_data), 256'h0);
        check({tag, "_dina"}, o_state_dina, 256'h0);
        check({tag, "_rd_data"}, o_rd_data, 256'h0);
    endtask

    vec_t vecs[7];

    initial begin
        //           qbit ins tmo cdl stl gap stall | ctx st start cyc rd terr cerr
        vecs[0] = '{4,  3,  0, 10, 0, 0, 0,   3, 4, 1, 10, 4, 0, 0};
        vecs[1] = '{3,  5,  0,  4, 1, 1, 0,   5, 2, 1,  4, 2, 0, 0};
        vecs[2] = '{4,  2,  5,  0, 0, 0, 0,   2, 4, 1,  5, 0, 1, 0};
        vecs[3] = '{19, 2,  0,  5, 0, 0, 0,   0, 0, 0,  5, 0, 0, 1};
        vecs[4] = '{2,  0,  0,  3, 0, 0, 3,   0, 1, 1,  3, 1, 0, 0};
        vecs[5] = '{5,  1,  0,  7, 0, 0, 3,   1, 8, 1,  7, 8, 0, 0};
        vecs[6] = '{1,  1, 20,  2, 0, 0, 0,   1, 1, 1,  2, 1, 0, 0};

        rst_n = 1'b0; i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0; i_timeout = '0;
        i_ctx_valid = 1'b0; i_ctx_data = '0; i_complete = 1'b0; i_rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) do_run(vecs[i], $sformatf("v%0d", i));

        // Reset while waiting for completion, with a simultaneous go: reset wins.
        begin_run('{3, 1, 0, 0, 0, 0, 0, 1, 2, 1, 0, 2, 0, 0});
        for (int c = 0; c < 200 && !(started && since == 3); c++) step();
        check("mid_wait_reached", 256'(started && since == 3 && o_busy), 256'(1));
        rst_n = 1'b0;
        i_go  = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        i_go  = 1'b0;
        rst_n = 1'b1;
        do_run(vecs[0], "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
